// File: rtl/simple_st0_tap_mem_if.sv
// simple_st0_tap_mem_if: read/write/clear request bundle and status outputs of simple_st0_tap_mem
interface simple_st0_tap_mem_if #(
  parameter int unsigned WORDS = 6
);
  logic [3:0]          tap_int_rd_address;
  logic                tap_int_rd_vld;
  logic [3:0]          tap_int_wr_address;
  logic                tap_int_wr_vld;
  logic                tap_int_sub_vld;
  logic [31:0]         tap_int_sub_addr;
  logic [31:0]         tap_int_sub_data;
  logic [32*WORDS-1:0] tap_int_wr_data;
  logic                clear;
  logic [32*WORDS-1:0] tap_int_rd_data;
  logic                tap_int_rd_data_vld;
  logic                busy;
  logic                sub_err;
  logic [7:0]          drop_count;
  modport master (
    output tap_int_rd_address, tap_int_rd_vld, tap_int_wr_address, tap_int_wr_vld,
           tap_int_sub_vld, tap_int_sub_addr, tap_int_sub_data, tap_int_wr_data, clear,
    input  tap_int_rd_data, tap_int_rd_data_vld, busy, sub_err, drop_count
  );
  modport slave (
    input  tap_int_rd_address, tap_int_rd_vld, tap_int_wr_address, tap_int_wr_vld,
           tap_int_sub_vld, tap_int_sub_addr, tap_int_sub_data, tap_int_wr_data, clear,
    output tap_int_rd_data, tap_int_rd_data_vld, busy, sub_err, drop_count
  );
endinterface

// File: rtl/simple_st0_tap_mem.sv
// simple_st0_tap_mem: tap-row memory with row/word writes, clear sweep and dropped-write accounting.
// Define SIMPLE_ST0_TAP_MEM_BYPASS_EN to forward same-cycle write data to a read of the same row.
module simple_st0_tap_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WORDS = 6
) (
  input logic                 clk,
  input logic                 reset,
  simple_st0_tap_mem_if.slave bus
);
  localparam int unsigned W = 32 * WORDS;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t       r_state, w_next;
  logic [W-1:0] r_mem [DEPTH];
  logic [3:0]   r_clr_idx;
  logic [W-1:0] r_rd_data;
  logic         r_rd_vld, r_sub_err;
  logic [7:0]   r_drop;
  logic         w_wr_ok, w_rd_ok, w_sub_bad, w_wr_en, w_drop, w_enter;
  logic [W-1:0] w_old, w_merge, w_new, w_rd_row;
  always_comb begin
    w_next = r_state == IDLE ? (bus.clear ? CLEAR : IDLE)
                             : ({28'd0, r_clr_idx} == DEPTH - 1 ? IDLE : CLEAR);
  end
  always_comb begin
    w_wr_ok   = {28'd0, bus.tap_int_wr_address} < DEPTH;
    w_rd_ok   = {28'd0, bus.tap_int_rd_address} < DEPTH;
    w_sub_bad = bus.tap_int_sub_vld && bus.tap_int_sub_addr >= WORDS;
    w_wr_en   = bus.tap_int_wr_vld && r_state == IDLE && w_wr_ok && !w_sub_bad;
    w_drop    = bus.tap_int_wr_vld && !w_wr_en;
    w_enter   = r_state == IDLE && bus.clear;
    w_old     = w_wr_ok ? r_mem[bus.tap_int_wr_address] : '0;
    w_merge   = w_old;
    w_merge[{bus.tap_int_sub_addr[2:0], 5'd0} +: 32] = bus.tap_int_sub_data;
    w_new     = bus.tap_int_sub_vld ? w_merge : bus.tap_int_wr_data;
`ifdef SIMPLE_ST0_TAP_MEM_BYPASS_EN
    w_rd_row  = (w_wr_en && bus.tap_int_wr_address == bus.tap_int_rd_address) ? w_new
              : (w_rd_ok ? r_mem[bus.tap_int_rd_address] : '0);
`else
    w_rd_row  = w_rd_ok ? r_mem[bus.tap_int_rd_address] : '0;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // The sweep owns the array while busy; requests in that window are only counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem     <= '{default: '0};
      r_clr_idx <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_sub_err <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_rd_vld <= bus.tap_int_rd_vld;
      if (bus.tap_int_rd_vld) r_rd_data <= w_rd_row;
      if (r_state == CLEAR) begin
        r_mem[r_clr_idx] <= '0;
        r_clr_idx        <= r_clr_idx + 4'd1;
      end else begin
        r_clr_idx <= '0;
        if (w_wr_en) r_mem[bus.tap_int_wr_address] <= w_new;
      end
      if (w_enter) begin
        r_sub_err <= 1'b0;
        r_drop    <= '0;
      end else begin
        if (bus.tap_int_wr_vld && w_sub_bad && r_state == IDLE) r_sub_err <= 1'b1;
        if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end
  assign bus.tap_int_rd_data     = r_rd_data;
  assign bus.tap_int_rd_data_vld = r_rd_vld;
  assign bus.busy                = r_state == CLEAR;
  assign bus.sub_err             = r_sub_err;
  assign bus.drop_count          = r_drop;
endmodule

// File: doc/simple_st0_tap_mem.md
SIMPLE_ST0_TAP_MEM -- requirements
Module: simple_st0_tap_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of tap rows.
REQ-002 SHALL have parameter WORDS, default 6, meaning 32-bit words per row; row width = 32*WORDS (192).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tap_int_rd_address  input  4  read row.
REQ-006 SHALL have port tap_int_rd_vld  input  1  read request.
REQ-007 SHALL have port tap_int_wr_address  input  4  write row.
REQ-008 SHALL have port tap_int_wr_vld  input  1  write request.
REQ-009 SHALL have port tap_int_sub_vld  input  1  qualifies write as single-word write.
REQ-010 SHALL have port tap_int_sub_addr  input  32  word index; only bits [2:0] decoded, bits [31:3] must be zero.
REQ-011 SHALL have port tap_int_sub_data  input  32  single-word write data.
REQ-012 SHALL have port tap_int_wr_data  input  192  full-row write data.
REQ-013 SHALL have port clear  input  1  pulse starting memory clear sweep.
REQ-014 SHALL have port tap_int_rd_data  output  192  registered read data.
REQ-015 SHALL have port tap_int_rd_data_vld  output  1  one-cycle pulse, read data valid.
REQ-016 SHALL have port busy  output  1  high while clear sweep active.
REQ-017 SHALL have port sub_err  output  1  sticky illegal sub-word write flag.
REQ-018 SHALL have port drop_count  output  8  saturating count of dropped writes.

Function
REQ-019 SHALL treat wr_vld=1, sub_vld=0 as full-row write: row[wr_address] <= wr_data at that clock edge.
REQ-020 SHALL treat wr_vld=1, sub_vld=1 as word write: word sub_addr[2:0] of row[wr_address] (bits 32k+31:32k) <= sub_data; other words unchanged.
REQ-021 SHALL drop a word write when sub_addr >= WORDS or sub_addr[31:3] != 0, set sub_err, and increment drop_count.
REQ-022 SHALL ignore sub_vld=1 with wr_vld=0 (no write, no flag, no count).
REQ-023 SHALL return rd_data = row[rd_address] one cycle after rd_vld=1 and pulse rd_data_vld in that same cycle; latency exactly 1.
REQ-024 SHALL hold tap_int_rd_data at its last value when no read was issued the previous cycle.
REQ-025 SHALL ignore rd_address/wr_address >= DEPTH: reads return zero with rd_data_vld=1, writes drop and increment drop_count.
REQ-026 SHALL, on a same-cycle read and write to one row without the bypass feature, return pre-write (old) contents.
REQ-027 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR on clear=1; CLEAR zeros one row per cycle, rows 0..DEPTH-1 in order; CLEAR->IDLE after row DEPTH-1 is cleared (DEPTH cycles); busy=1 exactly in CLEAR.
REQ-028 SHALL ignore clear while in CLEAR (no restart).
REQ-029 SHALL drop every write request during CLEAR and increment drop_count per dropped request.
REQ-030 SHALL serve reads during CLEAR from current contents (already-cleared rows read zero).
REQ-031 SHALL clear sub_err and drop_count when CLEAR is entered.
REQ-032 SHALL saturate drop_count at 255.

Reset
REQ-033 SHALL, with reset low, asynchronously force all rows to zero, FSM to IDLE, rd_data=0, rd_data_vld=0, busy=0, sub_err=0, drop_count=0.
REQ-034 SHALL abort an in-progress CLEAR on reset and return to IDLE with the REQ-033 values.

Configuration
REQ-035 SHALL, with SIMPLE_ST0_TAP_MEM_BYPASS_EN defined, forward same-cycle write data to a read of the same row (full row, or merged word for word writes) so new data is returned.
REQ-036 SHALL, without SIMPLE_ST0_TAP_MEM_BYPASS_EN, behave per REQ-026 with no forwarding logic.

Verification
REQ-037 SHALL cover: full write row 3 = 192'hA5..A5, then read row 3 -> rd_data=192'hA5..A5 one cycle later, rd_data_vld pulse of 1 cycle.
REQ-038 SHALL cover: row 5 = 0, word write sub_addr=2, sub_data=32'hDEADBEEF -> read row 5 shows bits[95:64]=32'hDEADBEEF, all other bits 0.
REQ-039 SHALL cover: word write sub_addr=6 -> row unchanged, sub_err=1, drop_count=1.
REQ-040 SHALL cover: same-cycle write 32'h1 to row 7 (old value 0) plus read row 7 -> 0 without macro, 32'h1 with SIMPLE_ST0_TAP_MEM_BYPASS_EN.
REQ-041 SHALL cover: clear pulse -> busy high exactly 16 cycles, 3 writes during sweep dropped (drop_count=3), all rows read 0 afterwards.
REQ-042 SHALL cover: reset asserted at sweep cycle 8 -> busy=0 immediately, all outputs 0, FSM IDLE on reset release.
